// File: rtl/foxtrot_mem_pkg.sv
// Shared types and constants for the memory-port arbiter and related blocks.
package foxtrot_mem_pkg;

  localparam int DEFAULT_ADDR_W = 64;
  localparam int DEFAULT_DATA_W = 64;

  // Stored channel-index width; wide enough for up to 256 read channels.
  localparam int CH_W = 8;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            drop;
  } inflight_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Reusable wherever a rotating-priority pick is needed.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    // NOTE: every output gets a default before the search loops so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (!grant_valid && req[c] && (c >= int'(ptr))) begin
        grant[c]    = 1'b1;
        grant_idx   = IDX_W'(c);
        grant_valid = 1'b1;
      end
    end
    // Wrap-around pass over the channels below ptr.
    for (int c = 0; c < N; c++) begin
      if (!grant_valid && req[c] && (c < int'(ptr))) begin
        grant[c]    = 1'b1;
        grant_idx   = IDX_W'(c);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges N_RD read channels and one write channel onto single memory ports, with
// in-order read tracking and per-channel flush. Define MEM_ARB_STATS_EN for counters.
module mem_port_arbiter
  import foxtrot_mem_pkg::*;
#(
  parameter int N_RD            = 2,
  parameter int ADDR_W          = DEFAULT_ADDR_W,
  parameter int DATA_W          = DEFAULT_DATA_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CH_BITS         = (N_RD > 1) ? $clog2(N_RD) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_RD-1:0]               rd_req_valid,
  output logic [N_RD-1:0]               rd_req_ready,
  input  logic [N_RD-1:0][ADDR_W-1:0]   rd_req_addr,
  output logic [N_RD-1:0]               rd_rsp_valid,
  output logic [N_RD-1:0][DATA_W-1:0]   rd_rsp_data,
  input  logic                          flush_valid,
  input  logic [N_RD-1:0]               flush_mask,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_ren,
  output logic [ADDR_W-1:0]             mem_raddr,
  input  logic                          mem_rvalid,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          mem_wen,
  output logic [ADDR_W-1:0]             mem_waddr,
  output logic [DATA_W-1:0]             mem_wdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [N_RD-1:0][31:0]         stat_grants,
  output logic [N_RD-1:0][31:0]         stat_stalls,
  output logic [31:0]                   stat_dropped
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  inflight_entry_t fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CH_BITS-1:0] rr_ptr_q;

  logic               pop, push, can_issue;
  logic [N_RD-1:0]    eligible, grant;
  logic [CH_BITS-1:0] grant_idx;
  logic               grant_valid;
  logic [MAX_OUTSTANDING-1:0] entry_flushed;
  logic [N_RD-1:0]    head_onehot;
  logic               head_drop;

  // An empty tracker means the response belongs to nobody (e.g. after reset).
  assign pop       = mem_rvalid && (count_q != '0);
  assign can_issue = (count_q < CNT_W'(MAX_OUTSTANDING)) || pop;
  assign eligible  = rd_req_valid & ~({N_RD{flush_valid}} & flush_mask);

  rr_arbiter #(.N(N_RD), .IDX_W(CH_BITS)) u_rr (
    .req         (eligible),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign push         = rst && can_issue && grant_valid;
  assign rd_req_ready = push ? grant : '0;
  assign wr_ready     = rst;

  always_comb begin
    entry_flushed = '0;
    head_onehot   = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      for (int c = 0; c < N_RD; c++) begin
        if (flush_valid && flush_mask[c] && (fifo_q[i].ch == CH_W'(c))) entry_flushed[i] = 1'b1;
      end
    end
    for (int c = 0; c < N_RD; c++) begin
      if (fifo_q[rd_ptr_q].ch == CH_W'(c)) head_onehot[c] = 1'b1;
    end
  end

  // A flush in the same cycle as the pop still suppresses that response.
  assign head_drop = fifo_q[rd_ptr_q].drop || entry_flushed[rd_ptr_q];

  // NOTE: the tracker storage has no reset; validity comes only from the reset
  // pointers and count, so clearing the array would add logic for nothing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (entry_flushed[i]) fifo_q[i].drop <= 1'b1;
    end
    if (push) fifo_q[wr_ptr_q] <= '{ch: CH_W'(grant_idx), drop: 1'b0};
  end

  // NOTE: state registers use non-blocking assignment so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      mem_ren      <= 1'b0;
      mem_raddr    <= '0;
      rd_rsp_valid <= '0;
      rd_rsp_data  <= '0;
      mem_wen      <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + 1'b1;
        rr_ptr_q  <= (grant_idx == CH_BITS'(N_RD - 1)) ? '0 : grant_idx + 1'b1;
        mem_raddr <= rd_req_addr[grant_idx];
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      mem_ren      <= push;
      rd_rsp_valid <= (pop && !head_drop) ? head_onehot : '0;
      for (int c = 0; c < N_RD; c++) begin
        if (pop && !head_drop && head_onehot[c]) rd_rsp_data[c] <= mem_rdata;
      end
      mem_wen <= wr_valid;
      if (wr_valid) begin
        mem_waddr <= wr_addr;
        mem_wdata <= wr_data;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_grants  <= '0;
      stat_stalls  <= '0;
      stat_dropped <= '0;
    end else begin
      for (int c = 0; c < N_RD; c++) begin
        if (rd_req_ready[c]) stat_grants[c] <= sat_inc(stat_grants[c]);
        if (rd_req_valid[c] && !rd_req_ready[c]) stat_stalls[c] <= sat_inc(stat_stalls[c]);
      end
      if (pop && head_drop) stat_dropped <= sat_inc(stat_dropped);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter plus a small reference model for the
// randomised-latency ordering run. Stats checks compile in with MEM_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N_RD   = 2;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MAXO   = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_RD-1:0]             rd_req_valid, rd_req_ready, rd_rsp_valid, flush_mask;
  logic [N_RD-1:0][ADDR_W-1:0] rd_req_addr;
  logic [N_RD-1:0][DATA_W-1:0] rd_rsp_data;
  logic                        flush_valid, wr_valid, wr_ready;
  logic [ADDR_W-1:0]           wr_addr, mem_raddr, mem_waddr;
  logic [DATA_W-1:0]           wr_data, mem_rdata, mem_wdata;
  logic                        mem_ren, mem_rvalid, mem_wen;
`ifdef MEM_ARB_STATS_EN
  logic [N_RD-1:0][31:0]       stat_grants, stat_stalls;
  logic [31:0]                 stat_dropped;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_RD(N_RD), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .flush_valid  (flush_valid),
    .flush_mask   (flush_mask),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_grants  (stat_grants),
    .stat_stalls  (stat_stalls),
    .stat_dropped (stat_dropped)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_req_valid = '0;
    rd_req_addr  = '0;
    flush_valid  = 1'b0;
    flush_mask   = '0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
  endtask

  // Inputs change 1ns after the edge; checks run 1ns later, far from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    next_cycle();
    rst = 1'b1;
  endtask

  typedef struct {
    int          ch;
    logic [63:0] addr;
    int          due;
  } mreq_t;

  localparam logic [63:0] DKEY = 64'hDEAD_BEEF_0000_0000;

  mreq_t           memq[$];
  mreq_t           ent;
  int              m_ptr, m_cnt, issued, returned, last_due, g, exp_rch;
  logic            m_pop, m_can, exp_ren;
  logic [N_RD-1:0] exp_rv, exp_ready;
  logic [63:0]     exp_rdata, exp_raddr;

  initial begin
    rst = 1'b0;
    idle();

    // Reset: handshakes held low even with requests pending, outputs cleared.
    rd_req_valid = 2'b11;
    wr_valid     = 1'b1;
    next_cycle();
    settle();
    check("rst_rd_ready", rd_req_ready, 2'b00);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_mem_ren", mem_ren, 1'b0);
    check("rst_mem_wen", mem_wen, 1'b0);
    check("rst_rsp_valid", rd_rsp_valid, 2'b00);
    check("rst_rsp_data0", rd_rsp_data[0], 64'h0);
    check("rst_raddr", mem_raddr, 64'h0);
    next_cycle();
    rst = 1'b1;
    idle();

    // Single read: issue at T, memory data at T+3, response at T+4.
    rd_req_valid   = 2'b01;
    rd_req_addr[0] = 64'h1000;
    settle();
    check("single_ready", rd_req_ready, 2'b01);
    next_cycle();
    idle();
    settle();
    check("single_ren", mem_ren, 1'b1);
    check("single_raddr", mem_raddr, 64'h1000);
    check("single_rsp_t1", rd_rsp_valid, 2'b00);
    next_cycle();
    settle();
    check("single_ren_off", mem_ren, 1'b0);
    check("single_rsp_t2", rd_rsp_valid, 2'b00);
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hDEAD;
    settle();
    check("single_rsp_t3", rd_rsp_valid, 2'b00);
    next_cycle();
    idle();
    settle();
    check("single_rsp_valid", rd_rsp_valid, 2'b01);
    check("single_rsp_data", rd_rsp_data[0], 64'hDEAD);
    next_cycle();
    settle();
    check("single_rsp_clear", rd_rsp_valid, 2'b00);
    check("single_data_hold", rd_rsp_data[0], 64'hDEAD);

    // Fairness: both channels request for 8 cycles, grants alternate from ch0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      rd_req_valid   = (i < 8) ? 2'b11 : 2'b00;
      rd_req_addr[0] = 64'h2000 + 64'(i);
      rd_req_addr[1] = 64'h2100 + 64'(i);
      mem_rvalid     = (i >= 1);
      mem_rdata      = 64'h100 + 64'(i);
      settle();
      if (i < 8) check($sformatf("fair_ready_%0d", i), rd_req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i >= 2) begin
        check($sformatf("fair_rsp_%0d", i), rd_rsp_valid, ((i - 2) % 2 == 1) ? 2'b10 : 2'b01);
        check($sformatf("fair_data_%0d", i), rd_rsp_data[(i - 2) % 2], 64'h100 + 64'(i - 1));
      end
      next_cycle();
    end
    idle();
    settle();
    check("fair_rsp_last", rd_rsp_valid, 2'b10);
    check("fair_data_last", rd_rsp_data[1], 64'h108);
`ifdef MEM_ARB_STATS_EN
    check("stat_grants0", stat_grants[0], 32'd4);
    check("stat_grants1", stat_grants[1], 32'd4);
    check("stat_stalls0", stat_stalls[0], 32'd4);
    check("stat_stalls1", stat_stalls[1], 32'd4);
`endif
    next_cycle();

    // Full tracker: four reads fill it, the fifth waits until a same-cycle pop.
    for (int i = 0; i < 4; i++) begin
      idle();
      rd_req_valid   = 2'b01;
      rd_req_addr[0] = 64'h3000 + 64'(i);
      settle();
      check($sformatf("full_ready_%0d", i), rd_req_ready, 2'b01);
      next_cycle();
    end
    rd_req_valid = 2'b01;
    settle();
    check("full_blocked", rd_req_ready, 2'b00);
    next_cycle();
    rd_req_valid = 2'b01;
    mem_rvalid   = 1'b1;
    mem_rdata    = 64'h55;
    settle();
    check("full_pop_grant", rd_req_ready, 2'b01);
    next_cycle();
    mem_rvalid = 1'b0;
    settle();
    check("full_still_full", rd_req_ready, 2'b00);
    check("full_pop_ren", mem_ren, 1'b1);
    check("full_pop_rsp", rd_rsp_valid, 2'b01);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h55;
      next_cycle();
    end
    idle();
    next_cycle();

    // Flush: ch0, ch1, ch0 in flight, then flush ch0 -> only ch1 responds.
    rd_req_valid = 2'b01;
    settle();
    check("flush_iss0", rd_req_ready, 2'b01);
    next_cycle();
    rd_req_valid = 2'b10;
    settle();
    check("flush_iss1", rd_req_ready, 2'b10);
    next_cycle();
    rd_req_valid = 2'b01;
    settle();
    check("flush_iss2", rd_req_ready, 2'b01);
    next_cycle();
    idle();
    flush_valid = 1'b1;
    flush_mask  = 2'b01;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      idle();
      mem_rvalid = (i < 3);
      mem_rdata  = 64'hA0 + 64'(i);
      settle();
      if (i == 1) check("flush_rsp_a", rd_rsp_valid, 2'b00);
      if (i == 2) begin
        check("flush_rsp_b", rd_rsp_valid, 2'b10);
        check("flush_data_b", rd_rsp_data[1], 64'hA1);
        check("flush_data0_hold", rd_rsp_data[0], 64'h55);
      end
      if (i >= 3) check($sformatf("flush_rsp_%0d", i), rd_rsp_valid, 2'b00);
      next_cycle();
    end

    // Flush in the same cycle as the pop; flushed channel ineligible, ch1 unaffected.
    rd_req_valid   = 2'b01;
    rd_req_addr[0] = 64'h7000;
    settle();
    check("fpop_iss", rd_req_ready, 2'b01);
    next_cycle();
    rd_req_valid   = 2'b11;
    rd_req_addr[1] = 64'h7100;
    flush_valid    = 1'b1;
    flush_mask     = 2'b01;
    mem_rvalid     = 1'b1;
    mem_rdata      = 64'h77;
    settle();
    check("fpop_ready", rd_req_ready, 2'b10);
    next_cycle();
    idle();
    settle();
    check("fpop_suppressed", rd_rsp_valid, 2'b00);
    check("fpop_ren", mem_ren, 1'b1);
    check("fpop_raddr", mem_raddr, 64'h7100);
    next_cycle();
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h88;
    next_cycle();
    idle();
    settle();
    check("fpop_rsp1", rd_rsp_valid, 2'b10);
    check("fpop_data1", rd_rsp_data[1], 64'h88);
    check("fpop_data0", rd_rsp_data[0], 64'h55);
`ifdef MEM_ARB_STATS_EN
    check("stat_dropped", stat_dropped, 32'd3);
`endif
    next_cycle();

    // Ordering and wrap: 20 reads against a model with 1-5 cycle memory latency.
    do_reset();
    m_ptr = 0; m_cnt = 0; issued = 0; returned = 0; last_due = 0;
    exp_rv = '0; exp_rch = 0; exp_rdata = '0; exp_ren = 1'b0; exp_raddr = '0;
    for (int cyc = 0; cyc < 400 && returned < 20; cyc++) begin
      idle();
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memq[0].addr ^ DKEY;
      end
      for (int c = 0; c < N_RD; c++) begin
        rd_req_valid[c] = (issued < 20) && ($urandom_range(0, 2) != 0);
        rd_req_addr[c]  = 64'h4000_0000 + (64'(c) << 16) + 64'(cyc);
      end
      settle();
      check("ord_rsp_valid", rd_rsp_valid, exp_rv);
      if (exp_rv != '0) check("ord_rsp_data", rd_rsp_data[exp_rch], exp_rdata);
      check("ord_ren", mem_ren, exp_ren);
      if (exp_ren) check("ord_raddr", mem_raddr, exp_raddr);
      m_pop = mem_rvalid;
      m_can = (m_cnt < MAXO) || m_pop;
      g = -1;
      if (m_can) begin
        for (int k = 0; k < N_RD; k++) begin
          if (g < 0 && rd_req_valid[(m_ptr + k) % N_RD]) g = (m_ptr + k) % N_RD;
        end
      end
      exp_ready = (g >= 0) ? N_RD'(1 << g) : '0;
      check("ord_ready", rd_req_ready, exp_ready);
      exp_rv = '0;
      if (m_pop) begin
        ent       = memq.pop_front();
        exp_rv    = N_RD'(1 << ent.ch);
        exp_rch   = ent.ch;
        exp_rdata = ent.addr ^ DKEY;
        returned++;
        m_cnt--;
      end
      exp_ren = (g >= 0);
      if (g >= 0) begin
        ent.ch   = g;
        ent.addr = rd_req_addr[g];
        ent.due  = cyc + 1 + $urandom_range(1, 5);
        if (ent.due <= last_due) ent.due = last_due + 1;
        last_due  = ent.due;
        exp_raddr = ent.addr;
        memq.push_back(ent);
        m_cnt++;
        issued++;
        m_ptr = (g + 1) % N_RD;
      end
      next_cycle();
    end
    idle();
    settle();
    check("ord_rsp_final", rd_rsp_valid, exp_rv);
    if (exp_rv != '0) check("ord_data_final", rd_rsp_data[exp_rch], exp_rdata);
    check("ord_returned", returned, 20);
    next_cycle();

    // Reset with three reads outstanding: later memory data is ignored.
    for (int i = 0; i < 3; i++) begin
      idle();
      rd_req_valid = 2'b01;
      settle();
      check($sformatf("rmf_iss_%0d", i), rd_req_ready, 2'b01);
      next_cycle();
    end
    idle();
    rst          = 1'b0;
    rd_req_valid = 2'b01;
    wr_valid     = 1'b1;
    settle();
    check("rmf_rd_ready", rd_req_ready, 2'b00);
    check("rmf_wr_ready", wr_ready, 1'b0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_rvalid = (i < 3);
      mem_rdata  = 64'h99;
      settle();
      check($sformatf("rmf_rsp_%0d", i), rd_rsp_valid, 2'b00);
      next_cycle();
    end

    // Write alongside a read; then four more reads fill an empty tracker exactly.
    rd_req_valid   = 2'b01;
    rd_req_addr[0] = 64'h5000;
    wr_valid       = 1'b1;
    wr_addr        = 64'h6000;
    wr_data        = 64'hBEEF;
    settle();
    check("wr_ready", wr_ready, 1'b1);
    check("wr_rd_ready", rd_req_ready, 2'b01);
    next_cycle();
    idle();
    rd_req_valid = 2'b01;
    settle();
    check("wr_ren", mem_ren, 1'b1);
    check("wr_raddr", mem_raddr, 64'h5000);
    check("wr_wen", mem_wen, 1'b1);
    check("wr_waddr", mem_waddr, 64'h6000);
    check("wr_wdata", mem_wdata, 64'hBEEF);
    check("rmf_fill_1", rd_req_ready, 2'b01);
    next_cycle();
    settle();
    check("wr_wen_off", mem_wen, 1'b0);
    check("rmf_fill_2", rd_req_ready, 2'b01);
    next_cycle();
    settle();
    check("rmf_fill_3", rd_req_ready, 2'b01);
    next_cycle();
    settle();
    check("rmf_fill_full", rd_req_ready, 2'b00);
    next_cycle();
    idle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the CPU's fixed pair of memory ports (fetch read port plus data read/write port).
- Merges N_RD independent read channels (fetch, LSU, future prefetcher) and one write channel onto a single memory read port and a single memory write port.
- Round-robin read arbitration, in-order tracking of outstanding reads, response routing back to the requesting channel.
- Per-channel flush drops stale responses after a PC redirect or ROB flush.

Parameters:
- N_RD, 2, number of read channels (≥1).
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MAX_OUTSTANDING, 4, in-flight read FIFO depth (power of 2, ≥2).
- CH_BITS, $clog2(N_RD) (min 1), derived channel-index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- rd_req_valid  in  [N_RD]  channel read request
- rd_req_ready  out  [N_RD]  grant; transfer when valid&ready
- rd_req_addr  in  [N_RD][ADDR_W]  request address
- rd_rsp_valid  out  [N_RD]  response strobe, one cycle
- rd_rsp_data  out  [N_RD][DATA_W]  response data
- flush_valid  in  1  flush strobe
- flush_mask  in  [N_RD]  channels whose in-flight reads are dropped
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- mem_ren  out  1  memory read enable
- mem_raddr  out  ADDR_W  memory read address
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_W  memory read data
- mem_wen  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs, rr_ptr, FIFO pointers and count clear to 0.
  - rd_req_ready and wr_ready are held 0 while rst==0.
  - Reset mid-operation discards every in-flight read; any later mem_rvalid is ignored.
- Memory contract:
  - Reads return in issue order, latency ≥1 cycle, no backpressure.
  - mem_rvalid with count==0 is ignored.
- Read grant (combinational):
  - Eligible channel: rd_req_valid[c] && !(flush_valid && flush_mask[c]).
  - Can-issue: count<MAX_OUTSTANDING, or count==MAX_OUTSTANDING and mem_rvalid this cycle (pop frees a slot).
  - If can-issue, grant the first eligible channel at or after rr_ptr, wrapping modulo N_RD. At most one rd_req_ready high per cycle.
- On a grant to channel g at cycle T:
  - At T+1: mem_ren=1 and mem_raddr=addr (registered). mem_ren is 0 otherwise.
  - Push {ch=g, drop=0} into the FIFO.
  - rr_ptr <= (g+1) mod N_RD. rr_ptr is unchanged when there is no grant.
- Response (cycle T, mem_rvalid=1):
  - Pop the head entry.
  - If drop==0, at T+1 rd_rsp_valid[ch]=1 and rd_rsp_data[ch]=mem_rdata. All other rd_rsp_valid are 0.
  - If drop==1, the data is consumed silently.
  - rd_rsp_data holds its last value when valid is low.
- Simultaneous push and pop: count is unchanged; both pointers advance, wrapping at MAX_OUTSTANDING.
- Flush (flush_valid=1 at cycle T):
  - Every FIFO entry with flush_mask[ch]==1 gets drop=1, including the entry popped in cycle T. That pop's response is suppressed.
  - The entry pushed in T is never flushed, because its channel was ineligible.
  - Unmasked channels are unaffected.
- Write path:
  - wr_ready = 1 unless reset.
  - On wr_valid&wr_ready, at the next cycle mem_wen=1 with mem_waddr and mem_wdata registered.
  - Writes are independent of reads. Ordering against reads is the LSU's responsibility.

Optional Feature:
MEM_ARB_STATS_EN
- Defined:
  - Extra output ports stat_grants [N_RD][32] count granted reads per channel.
  - Extra output ports stat_stalls [N_RD][32] count cycles with rd_req_valid&&!rd_req_ready.
  - Extra output port stat_dropped [32] counts suppressed responses.
  - All counters saturate at 2^32-1 and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package foxtrot_mem_pkg:
  - inflight_entry_t struct {ch, drop}.
  - Default-width constants (ADDR_W/DATA_W = 64).
- One sub-module rr_arbiter: parametrised N, req vector and ptr in, one-hot grant plus index out. Purely combinational, reusable by the issue queues.

Test Plan:
- Single read: ch0 requests 0x1000 at T, memory returns 0xDEAD at T+3 -> mem_ren at T+1 with raddr 0x1000; rd_rsp_valid[0] at T+4 with data 0xDEAD; rd_rsp_valid[1]=0 throughout.
- Fairness: N_RD=2, both channels request continuously -> grants alternate 0,1,0,1 starting from ch0 after reset; 8 grants give stat_grants 4/4 with MEM_ARB_STATS_EN.
- Full FIFO: 4 reads issued with no mem_rvalid -> 5th request sees ready=0. mem_rvalid then pops one -> same-cycle grant occurs and count stays 4.
- Flush: ch0 has 2 reads in flight, ch1 has 1, then flush_mask=2'b01 -> the three responses produce only rd_rsp_valid[1]; stat_dropped=2.
- Wrap/ordering: 20 interleaved reads with random 1-5 cycle latency -> each response goes to the issuing channel in order, and pointers wrap correctly past 3.
- Reset mid-flight: rst=0 for one cycle with 3 reads outstanding, then 3 mem_rvalid -> no rd_rsp_valid and count stays 0. A write issued the same cycle as a read -> mem_wen and mem_ren both high the next cycle.
